// File: rtl/preset_updown_counter.sv
// Bounded up/down counter with a DEPTH-entry preset register file; entry 0 holds the limit.
// Wrap or saturate at the 0..limit boundary, with a registered terminal-count flag and readback.
module preset_updown_counter #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_sync,
  input  logic          i_we,
  input  logic [AW-1:0] i_adr,
  input  logic [W-1:0]  i_value,
  input  logic          i_load,
  input  logic          i_enable,
  input  logic          i_updown,
  input  logic          i_sat_mode,
  output logic [W-1:0]  o_out,
  output logic          o_tc,
  output logic [W-1:0]  o_rd_data
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_regs [DEPTH];
  logic [W-1:0] r_out;
  logic         r_tc;
  logic [W-1:0] r_rd_data;

  logic [W-1:0] w_limit;
  logic [W-1:0] w_src;
  logic [W-1:0] w_out_nxt;
  logic         w_tc_nxt;

  assign w_limit = r_regs[0];
  // A simultaneous write always targets the load address, so the bypass reduces to i_we.
  assign w_src   = i_we ? i_value : r_regs[i_adr];

  // Next counter value and boundary flag.
  always_comb begin
    w_out_nxt = r_out;
    w_tc_nxt  = 1'b0;
    if (i_load) begin
      if (w_src > w_limit) begin
        w_out_nxt = w_limit;
      end else begin
        w_out_nxt = w_src;
      end
    end else if (i_enable) begin
      if (i_updown) begin
        if (r_out < w_limit) begin
          w_out_nxt = r_out + ONE;
        end else begin
          w_out_nxt = i_sat_mode ? w_limit : ZERO;
          w_tc_nxt  = 1'b1;
        end
      end else begin
        // Limit lowered underneath the counter: snap back into range without a boundary event.
        if (r_out > w_limit) begin
          w_out_nxt = w_limit;
        end else if (r_out != ZERO) begin
          w_out_nxt = r_out - ONE;
        end else begin
          w_out_nxt = i_sat_mode ? ZERO : w_limit;
          w_tc_nxt  = 1'b1;
        end
      end
    end else begin
      w_out_nxt = r_out;
    end
  end

  // Preset register file.
  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= ZERO;
      end
      r_regs[0] <= ONES;
    end else if (i_we) begin
      r_regs[i_adr] <= i_value;
    end
  end

  // Counter, terminal-count flag and pre-write readback.
  always_ff @(posedge i_clk) begin
    if (i_rst_sync) begin
      r_out     <= ZERO;
      r_tc      <= 1'b0;
      r_rd_data <= ZERO;
    end else begin
      r_out     <= w_out_nxt;
      r_tc      <= w_tc_nxt;
      r_rd_data <= r_regs[i_adr];
    end
  end

  assign o_out     = r_out;
  assign o_tc      = r_tc;
  assign o_rd_data = r_rd_data;

endmodule

// File: tb/tb_preset_updown_counter.sv
// Directed walk-through plus randomized run against an integer reference model of the counter.
module tb_preset_updown_counter;

  logic       clk = 1'b0;
  logic       rst_sync;
  logic       we;
  logic [3:0] adr;
  logic [7:0] value;
  logic       load;
  logic       enable;
  logic       updown;
  logic       sat_mode;
  logic [7:0] out;
  logic       tc;
  logic [7:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  int m_regs [16];
  int m_out;
  int m_tc;
  int m_rd;

  preset_updown_counter #(.W(8), .DEPTH(16), .AW(4)) dut (
    .i_clk      (clk),
    .i_rst_sync (rst_sync),
    .i_we       (we),
    .i_adr      (adr),
    .i_value    (value),
    .i_load     (load),
    .i_enable   (enable),
    .i_updown   (updown),
    .i_sat_mode (sat_mode),
    .o_out      (out),
    .o_tc       (tc),
    .o_rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: applies the counter rules to plain integers for one clock edge.
  task automatic model_edge(input int r, input int w, input int a, input int v,
                            input int ld, input int en, input int up, input int sat);
    int lim;
    int src;
    int rd_new;
    if (r != 0) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_regs[0] = 255;
      m_out = 0;
      m_tc  = 0;
      m_rd  = 0;
    end else begin
      lim    = m_regs[0];
      rd_new = m_regs[a];
      m_tc   = 0;
      if (ld != 0) begin
        src   = (w != 0) ? v : m_regs[a];
        m_out = (src > lim) ? lim : src;
      end else if (en != 0) begin
        if (up != 0) begin
          if (m_out < lim) m_out = m_out + 1;
          else begin m_out = (sat != 0) ? lim : 0; m_tc = 1; end
        end else begin
          if (m_out > lim) m_out = lim;
          else if (m_out > 0) m_out = m_out - 1;
          else begin m_out = (sat != 0) ? 0 : lim; m_tc = 1; end
        end
      end
      if (w != 0) m_regs[a] = v;
      m_rd = rd_new;
    end
  endtask

  task automatic cycle(input logic r, input logic w, input logic [3:0] a, input logic [7:0] v,
                       input logic ld, input logic en, input logic up, input logic sat);
    rst_sync = r; we = w; adr = a; value = v;
    load = ld; enable = en; updown = up; sat_mode = sat;
    @(posedge clk);
    model_edge(int'(r), int'(w), int'(a), int'(v), int'(ld), int'(en), int'(up), int'(sat));
    #1;
    check("model_out", 32'(out), 32'(m_out));
    check("model_tc", 32'(tc), 32'(m_tc));
    check("model_rd", 32'(rd_data), 32'(m_rd));
  endtask

  initial begin
    logic [7:0] exp_up [5];
    logic [7:0] exp_wrap [4];
    logic       exp_wrap_tc [4];
    logic [7:0] exp_sat [4];
    logic       exp_sat_tc [4];
    exp_up      = '{8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    exp_wrap    = '{8'd19, 8'd20, 8'd0, 8'd1};
    exp_wrap_tc = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_sat     = '{8'd1, 8'd0, 8'd0, 8'd0};
    exp_sat_tc  = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Reset and readback of the full-range limit.
    cycle(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    cycle(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rd_limit", 32'(rd_data), 32'd255);

    // Preset load and count up.
    cycle(1'b0, 1'b1, 4'd15, 8'd11, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 4'd15, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("load15", 32'(out), 32'd11);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 4'd15, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("up_out", 32'(out), 32'(exp_up[i]));
      check("up_tc", 32'(tc), 32'd0);
    end

    // Limit 20, wrap mode.
    cycle(1'b0, 1'b1, 4'd0, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 4'd1, 8'd18, 1'b1, 1'b0, 1'b1, 1'b0);
    check("load18", 32'(out), 32'd18);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 4'd1, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("wrap_out", 32'(out), 32'(exp_wrap[i]));
      check("wrap_tc", 32'(tc), 32'(exp_wrap_tc[i]));
    end

    // Saturate mode counting down.
    cycle(1'b0, 1'b1, 4'd1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    check("load2", 32'(out), 32'd2);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 4'd1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("sat_out", 32'(out), 32'(exp_sat[i]));
      check("sat_tc", 32'(tc), 32'(exp_sat_tc[i]));
    end
    cycle(1'b0, 1'b0, 4'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_tc", 32'(tc), 32'd0);
    check("hold_out", 32'(out), 32'd0);

    // Clamp on load and write bypass.
    cycle(1'b0, 1'b1, 4'd3, 8'd30, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 4'd3, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("clamp", 32'(out), 32'd20);
    cycle(1'b0, 1'b1, 4'd5, 8'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    check("bypass", 32'(out), 32'd7);
    check("bypass_tc", 32'(tc), 32'd0);
    cycle(1'b0, 1'b0, 4'd5, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rd_reg5", 32'(rd_data), 32'd7);

    // Reset in the middle of counting.
    cycle(1'b0, 1'b1, 4'd2, 8'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    check("load9", 32'(out), 32'd9);
    cycle(1'b1, 1'b0, 4'd2, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_tc", 32'(tc), 32'd0);
    cycle(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("midrst_lim", 32'(rd_data), 32'd255);
    cycle(1'b0, 1'b0, 4'd15, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("midrst_r15", 32'(rd_data), 32'd0);

    // Randomized traffic, small limits favoured so boundaries are hit often.
    for (int i = 0; i < 3000; i++) begin
      logic       r_r;
      logic       r_w;
      logic [3:0] r_a;
      logic [7:0] r_v;
      r_r = ($urandom_range(0, 99) == 0);
      r_w = ($urandom_range(0, 3) == 0);
      r_a = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      r_v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
      cycle(r_r, r_w, r_a, r_v, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/preset_updown_counter.md
Name: preset_updown_counter

Overview:
- Parametrised successor to the register-file-plus-counter top level: one W-bit up/down counter with a DEPTH-entry preset register file.
- Entry 0 of the register file is the programmable count limit, giving a modulo range 0..limit.
- Adds two counting modes (wrap or saturate), a terminal-count flag, a limit clamp on load, and registered readback of the register file.
- Used wherever a loadable, bounded event or timing counter is needed.

Parameters:
- W, 8, counter and register data width.
- DEPTH, 16, number of register-file entries (power of two, at least 2).
- AW, 4, address width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_sync  in  1  synchronous active-high reset.
- we  in  1  register-file write enable.
- adr  in  AW  address for write, load source and readback.
- value  in  W  write data.
- load  in  1  load counter from regs[adr].
- enable  in  1  count enable.
- updown  in  1  count direction: 1 = up, 0 = down.
- sat_mode  in  1  boundary mode: 0 = wrap, 1 = saturate.
- out  out  W  counter value (registered).
- tc  out  1  terminal-count flag (registered).
- rd_data  out  W  registered readback of regs[adr].

Behaviour:
- One clock (clk); reset rst_sync is synchronous and active-high. Every state element updates on posedge clk only.
- Reset (rst_sync=1 at the edge): out=0, tc=0, rd_data=0, regs[1..DEPTH-1]=0, regs[0]=all ones (full range). Reset overrides we, load and enable in the same cycle.
- Write: when we=1, regs[adr] takes value at the edge.
- limit is always the current regs[0].
- Counter priority per edge: rst_sync > load > enable > hold.
- Load: out takes src, where src = value if (we && adr matches, i.e. write bypass), else regs[adr].
  - If src > limit, out = limit instead (clamp).
  - tc = 0 on a load cycle.
  - Latency 1: the loaded value is visible on out after the edge.
- Count up (enable=1, load=0, updown=1):
  - out < limit: out = out + 1, tc = 0.
  - out >= limit, wrap mode: out = 0, tc = 1.
  - out >= limit, saturate mode: out = limit, tc = 1.
- Count down (enable=1, load=0, updown=0):
  - out > limit: out = limit, tc = 0. This covers the case where the limit was lowered under the counter.
  - 0 < out <= limit: out = out - 1, tc = 0.
  - out == 0, wrap mode: out = limit, tc = 1.
  - out == 0, saturate mode: out = 0, tc = 1.
- Hold (enable=0, load=0): out unchanged, tc = 0.
- tc is high for exactly the cycle after each boundary event. In saturate mode with enable held at the boundary, tc stays high continuously.
- limit = 0: up and down both hit the boundary every enabled cycle; out stays 0 and tc = 1.
- rd_data is regs[adr] sampled at the edge (pre-write value, no bypass), latency 1. rd_data = 0 on reset.
- Arithmetic is unsigned, modulo 2^W internally. No X propagation from an undriven enable or load: both are treated as 0 after reset.
- Reset mid-count takes effect at the next edge regardless of enable or load.

Test Plan (W=8, DEPTH=16):
- Reset → out=0, tc=0, rd_data=0. Then adr=0, we=0 for one cycle → rd_data=255.
- Write regs[15]=11, load adr 15, enable up 5 cycles → out sequence 11,12,13,14,15,16; tc=0 throughout.
- Write regs[0]=20, load value 18, wrap mode, up 3 cycles → out 19,20,0. tc=1 only in the cycle out becomes 0. A further up cycle → out=1, tc=0.
- Saturate mode: load 2, down 4 cycles → out 1,0,0,0; tc=1 in each of the last two cycles. Drop enable → tc=0.
- Limit 20: write regs[3]=30, load adr 3 → out=20 (clamp). Same cycle we=1, load=1, adr=5, value=7 → out=7 (bypass), and regs[5]=7 confirmed via rd_data next cycle.
- Counting up at out=9 with enable=1, assert rst_sync one cycle → out=0, tc=0, regs[0] back to 255, regs[15]=0.
